// File: rtl/vlc_bit_packer.sv
// Packs right-aligned variable-length codewords MSB-first into 32-bit words,
// with a flush sequence that drains full words and a zero-padded tail word.
module vlc_bit_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_code,
  input  logic [5:0]  in_len,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_last,
  output logic        flush_done,
  output logic [15:0] word_count
);

  typedef enum logic [1:0] {PACK, DRAIN, DONE} state_t;

  state_t      state, state_next;
  logic [63:0] acc, acc_next, acc_base;
  logic [6:0]  fill, fill_next, fill_base, shamt;
  logic [5:0]  len_eff;
  logic [31:0] code_masked;
  logic        in_fire, out_fire;

  assign in_ready   = (state == PACK) && (fill <= 7'd32);
  assign out_valid  = (fill >= 7'd32) || ((state == DRAIN) && (fill != 7'd0));
  assign out_word   = acc[63:32];
  assign out_last   = (state == DRAIN) && (fill != 7'd0) && (fill <= 7'd32);
  assign flush_done = (state == DONE);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;

  always_comb begin
    len_eff     = (in_len > 6'd32) ? 6'd32 : in_len;
    code_masked = '0;
    if (len_eff != 6'd0)
      code_masked = in_code & (32'hFFFF_FFFF >> (6'd32 - len_eff));
  end

  // Accumulator is MSB-aligned: the pop is applied first, then the new
  // codeword is placed directly below the surviving bits.
  always_comb begin
    state_next = state;
    acc_base   = acc;
    fill_base  = fill;
    if (out_fire) begin
      acc_base  = acc << 32;
      fill_base = (fill >= 7'd32) ? (fill - 7'd32) : '0;
    end
    shamt     = 7'd64 - fill_base - {1'b0, len_eff};
    acc_next  = acc_base;
    fill_next = fill_base;
    if (in_fire) begin
      acc_next  = acc_base | ({32'h0, code_masked} << shamt);
      fill_next = fill_base + {1'b0, len_eff};
    end
    case (state)
      PACK:    if (flush) state_next = DRAIN;
      DRAIN:   if ((fill == 7'd0) || (out_fire && out_last)) state_next = DONE;
      DONE: begin
        state_next = PACK;
        acc_next   = '0;
        fill_next  = '0;
      end
      default: state_next = PACK;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= PACK;
      acc        <= '0;
      fill       <= '0;
      word_count <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      fill  <= fill_next;
      if (out_fire) word_count <= word_count + 16'd1;
    end
  end

endmodule
